// File: rtl/seq_addsub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, LSB first,
// with signed-overflow detection and optional saturation under a start/busy/done handshake.
module seq_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    input  logic             sat,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             ovf,
    output logic             cout
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;      // operand A, doubles as the result shift register
    logic [WIDTH-1:0]   b_q;      // operand B, already inverted for subtraction
    logic               carry_q;
    logic               sat_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               ovf_q;
    logic               cout_q;

    logic [DIGIT:0]     slice_d;
    logic [WIDTH-1:0]   a_d;
    logic               cin_msb_d;
    logic               cout_d;
    logic               ovf_d;
    logic               last_d;
    logic [WIDTH-1:0]   sat_val_d;
    logic [WIDTH-1:0]   sum_d;

    // One digit of the ripple add: low slices of A and B plus the running carry.
    assign slice_d = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};

    // Result digits enter at the top while the consumed A digits leave at the bottom.
    if (DIGIT == WIDTH) begin : g_single
        assign a_d = slice_d[DIGIT-1:0];
    end else begin : g_multi
        assign a_d = {slice_d[DIGIT-1:0], a_q[WIDTH-1:DIGIT]};
    end

    // On the final digit the slice MSB is the word MSB, so its carry-in falls out of the sum bit.
    assign cin_msb_d = slice_d[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    assign cout_d    = slice_d[DIGIT];
    assign ovf_d     = cin_msb_d ^ cout_d;
    assign last_d    = (cnt_q == CNT_W'(N - 1));
    assign sat_val_d = a_q[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign sum_d     = (sat_q && ovf_d) ? sat_val_d : a_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{m}};
                        carry_q <= m;
                        sat_q   <= sat;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_q >> DIGIT;
                    carry_q <= cout_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_d) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= sum_d;
                        ovf_q   <= ovf_d;
                        cout_q  <= cout_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign ovf  = ovf_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub: three configurations driven with directed and
// random operations, compared against a plain signed-arithmetic reference.
module tb_seq_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        st8, m8, s8, busy8, done8, ovf8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        st16, m16, s16, busy16, done16, ovf16, cout16;
    logic [15:0] a16, b16, sum16;
    logic        st12, m12, s12, busy12, done12, ovf12, cout12;
    logic [11:0] a12, b12, sum12;

    int n_vec = 0;
    int n_bad = 0;

    seq_addsub #(.WIDTH(8), .DIGIT(2)) u_dut8 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .m(m8), .sat(s8),
        .busy(busy8), .done(done8), .sum(sum8), .ovf(ovf8), .cout(cout8)
    );

    seq_addsub #(.WIDTH(16), .DIGIT(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(st16), .a(a16), .b(b16), .m(m16), .sat(s16),
        .busy(busy16), .done(done16), .sum(sum16), .ovf(ovf16), .cout(cout16)
    );

    seq_addsub #(.WIDTH(12), .DIGIT(4)) u_dut12 (
        .clk(clk), .rst(rst), .start(st12), .a(a12), .b(b12), .m(m12), .sat(s12),
        .busy(busy12), .done(done12), .sum(sum12), .ovf(ovf12), .cout(cout12)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int wid(input int sel);
        return (sel == 0) ? 8 : (sel == 1) ? 16 : 12;
    endfunction

    function automatic int ndig(input int sel);
        return (sel == 0) ? 4 : (sel == 1) ? 1 : 3;
    endfunction

    task automatic set_in(input int sel, input logic [15:0] av, input logic [15:0] bv,
                          input logic mv, input logic sv, input logic stv);
        case (sel)
            0: begin a8 = av[7:0]; b8 = bv[7:0]; m8 = mv; s8 = sv; st8 = stv; end
            1: begin a16 = av; b16 = bv; m16 = mv; s16 = sv; st16 = stv; end
            default: begin a12 = av[11:0]; b12 = bv[11:0]; m12 = mv; s12 = sv; st12 = stv; end
        endcase
    endtask

    // {busy, done, ovf, cout}
    function automatic logic [3:0] flags(input int sel);
        case (sel)
            0:       return {busy8, done8, ovf8, cout8};
            1:       return {busy16, done16, ovf16, cout16};
            default: return {busy12, done12, ovf12, cout12};
        endcase
    endfunction

    function automatic logic [15:0] sumv(input int sel);
        case (sel)
            0:       return 16'(sum8);
            1:       return sum16;
            default: return 16'(sum12);
        endcase
    endfunction

    // Reference: true signed result, range test for overflow, unsigned compare for carry.
    task automatic model(input int w, input longint av, input longint bv, input bit mv,
                         input bit sv, output longint rs, output bit ov, output bit co);
        longint full, half, sa, sb, r;
        full = longint'(1) << w;
        half = full / 2;
        sa = (av >= half) ? av - full : av;
        sb = (bv >= half) ? bv - full : bv;
        r  = mv ? sa - sb : sa + sb;
        ov = (r > half - 1) || (r < -half);
        co = mv ? (av >= bv) : (av + bv >= full);
        if (ov && sv) rs = (r > 0) ? half - 1 : half;
        else          rs = ((r % full) + full) % full;
    endtask

    // Issues one op and returns during the done cycle (start left at 'keep').
    task automatic op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                      input logic mv, input logic sv, input bit keep, input string tag);
        longint mask, er;
        bit eo, ec;
        int ticks, bcnt;
        logic [3:0] f;
        mask = (longint'(1) << wid(sel)) - 1;
        model(wid(sel), longint'(av) & mask, longint'(bv) & mask, mv, sv, er, eo, ec);
        set_in(sel, av, bv, mv, sv, 1'b1);
        tick();
        ticks = 1;
        bcnt  = 0;
        if (!keep) set_in(sel, av, bv, mv, sv, 1'b0);
        f = flags(sel);
        while (!f[2] && ticks < 40) begin
            if (f[3]) bcnt++;
            if (keep) set_in(sel, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            tick();
            ticks++;
            f = flags(sel);
        end
        check({tag, " latency"}, 32'(ticks), 32'(ndig(sel) + 1));
        check({tag, " busy_cycles"}, 32'(bcnt), 32'(ndig(sel)));
        check({tag, " busy_in_done"}, 32'(f[3]), 32'd0);
        check({tag, " sum"}, 32'(sumv(sel)), 32'(er));
        check({tag, " ovf"}, 32'(f[1]), 32'(eo));
        check({tag, " cout"}, 32'(f[0]), 32'(ec));
    endtask

    // Drop start, step past the done cycle, confirm the pulse ended and the result held.
    task automatic after_done(input int sel, input string tag);
        logic [15:0] held;
        held = sumv(sel);
        set_in(sel, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
        tick();
        check({tag, " done_pulse"}, 32'(flags(sel) >> 2), 32'd0);
        check({tag, " sum_hold"}, 32'(sumv(sel)), 32'(held));
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 3; s++) set_in(s, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset flags%0d", s), 32'(flags(s)), 32'd0);
            check($sformatf("reset sum%0d", s), 32'(sumv(s)), 32'd0);
        end
        rst = 1'b0;
        tick();

        // Directed additions, then subtractions.
        op(0, 16'd100, 16'd27, 1'b0, 1'b0, 1'b0, "add_127");
        check("add_127 sum_const", 32'(sum8), 32'h7F);
        after_done(0, "add_127");
        op(0, 16'd100, 16'd28, 1'b0, 1'b0, 1'b0, "add_ovf");
        check("add_ovf sum_const", 32'(sum8), 32'h80);
        after_done(0, "add_ovf");
        op(0, 16'd100, 16'd28, 1'b0, 1'b1, 1'b0, "add_sat");
        check("add_sat sum_const", 32'(sum8), 32'h7F);
        after_done(0, "add_sat");
        op(0, 16'd5, 16'd7, 1'b1, 1'b0, 1'b0, "sub_neg");
        check("sub_neg sum_const", 32'(sum8), 32'hFE);
        after_done(0, "sub_neg");
        op(0, 16'h80, 16'd1, 1'b1, 1'b0, 1'b0, "sub_ovf");
        after_done(0, "sub_ovf");
        op(0, 16'h80, 16'd1, 1'b1, 1'b1, 1'b0, "sub_sat");
        check("sub_sat sum_const", 32'(sum8), 32'h80);
        after_done(0, "sub_sat");

        // Start held high with operands churning during RUN.
        op(0, 16'd60, 16'd3, 1'b1, 1'b0, 1'b1, "hold_start");
        after_done(0, "hold_start");

        // Back-to-back: second start lands in the done cycle.
        op(0, 16'd10, 16'd20, 1'b0, 1'b0, 1'b0, "b2b_first");
        op(0, 16'hF0, 16'h20, 1'b1, 1'b1, 1'b0, "b2b_second");
        after_done(0, "b2b_second");

        // Reset during the second RUN cycle abandons the op.
        set_in(0, 16'd90, 16'd90, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(0, 16'd90, 16'd90, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst flags", 32'(flags(0)), 32'd0);
        check("midrst sum", 32'(sum8), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst no_done", 32'(done8), 32'd0);
        end
        op(0, 16'd33, 16'd44, 1'b0, 1'b0, 1'b0, "post_rst");
        after_done(0, "post_rst");

        // Other configurations.
        op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, "w16_ovf");
        check("w16_ovf sum_const", 32'(sum16), 32'h8000);
        after_done(1, "w16_ovf");
        op(2, 16'h0800, 16'h0001, 1'b1, 1'b1, 1'b0, "w12_sat");
        check("w12_sat sum_const", 32'(sum12), 32'h800);
        after_done(2, "w12_sat");

        // Random operations across all three configurations.
        for (int i = 0; i < 36; i++) begin
            int sel;
            sel = i % 3;
            op(sel, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
               bit'($urandom_range(0, 3) == 0), $sformatf("rnd%0d_cfg%0d", i, sel));
            after_done(sel, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
